pipe_skid_stage: RTL

Parametrised pipeline stage register with a valid/ready handshake, two-entry skid buffer, synchronous flush and bubble insertion. It is the next-generation replacement for the fixed-width stage registers such as IF/ID, ID/EX, EX/MEM and MEM/WB. A single instance carries any payload width. Backpressure (stall) propagates without a combinational ready path, and a flushed or empty stage presents a bubble whose control field is forced to a safe value, for example with RegWrite and MemWrite deasserted.

---
 rtl/pipe_pkg.sv | 48 ++++
 rtl/pipe_skid_stage.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: occupancy encoding,
// per-boundary control-field layouts and their safe bubble values.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic       pred_taken;
    logic [6:0] rsvd;
  } if_id_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
    logic [4:0] rd;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] rd;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] wb_sel;
    logic [4:0] rd;
  } mem_wb_ctrl_t;

  // Bubbles must never write state: all enables low, rd = x0.
  localparam logic [7:0]  IF_ID_BUBBLE  = '0;
  localparam logic [12:0] ID_EX_BUBBLE  = '0;
  localparam logic [8:0]  EX_MEM_BUBBLE = '0;
  localparam logic [8:0]  MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/pipe_skid_stage.sv
// Generic pipeline stage register: valid/ready handshake with a two-entry skid
// buffer, synchronous flush and a forced-safe control field on bubbles.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned         DATA_W      = 32,
  parameter int unsigned         CTRL_W      = 8,
  parameter logic [CTRL_W-1:0]   BUBBLE_CTRL = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InData,
  input  logic [CTRL_W-1:0] InCtrl,
  input  logic              Flush,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [CTRL_W-1:0] OutCtrl,
  output logic [1:0]        Occupancy
);

  occ_e              state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              push, pop;

  assign push = InValid & in_ready_q;
  assign pop  = main_valid_q & OutReady;

  always_comb begin
    state_d      = state_q;
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;

    if (Flush) begin
      // Data registers are left as-is; only the valid bits matter.
      state_d      = OCC_EMPTY;
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (push) begin
            state_d      = OCC_ONE;
            main_valid_d = 1'b1;
            main_data_d  = InData;
            main_ctrl_d  = InCtrl;
          end
        end
        OCC_ONE: begin
          if (push && !pop) begin
            state_d      = OCC_FULL;
            skid_valid_d = 1'b1;
            skid_data_d  = InData;
            skid_ctrl_d  = InCtrl;
          end else if (push && pop) begin
            main_data_d = InData;
            main_ctrl_d = InCtrl;
          end else if (pop) begin
            state_d      = OCC_EMPTY;
            main_valid_d = 1'b0;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            state_d      = OCC_ONE;
            main_data_d  = skid_data_q;
            main_ctrl_d  = skid_ctrl_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          state_d      = OCC_EMPTY;
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end

    // Registered ready keeps OutReady off any combinational path to InReady.
    in_ready_d = (state_d != OCC_FULL);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= OCC_EMPTY;
      in_ready_q   <= 1'b0;
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end

  assign InReady   = in_ready_q;
  assign OutValid  = main_valid_q;
  assign OutData   = main_data_q;
  assign OutCtrl   = main_valid_q ? main_ctrl_q : BUBBLE_CTRL;
  assign Occupancy = state_q;

endmodule
